vision_lane_controller: RTL and testbench

//  Per-frame controller after the vision quadrant detector. Consumes the 9-bit quadrant occupancy map
//  (bit k = quadrant k; rows 0-2/3-5/6-8 top->bottom, cols left->right) once per frame.

---
 rtl/vision_pkg.sv | 34 +++
 rtl/vision_lane_controller_if.sv | 32 +++
 rtl/vision_quadrant_decode.sv | 30 +++
 rtl/vision_lane_controller.sv | 172 +++++++++++++++++
 tb/tb_vision_lane_controller.sv | 162 ++++++++++++++++
 5 files changed

// File: rtl/vision_pkg.sv
// Shared types and constants for the vision lane controller slice.
// Quadrant k of the occupancy map is bit k: rows top->bottom, columns left->right.
package vision_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_TRACK    = 3'd1,
        ST_JUMP     = 3'd2,
        ST_COOLDOWN = 3'd3,
        ST_LOST     = 3'd4
    } ctrl_state_t;

    localparam logic [1:0] LANE_LEFT   = 2'd0;
    localparam logic [1:0] LANE_CENTRE = 2'd1;
    localparam logic [1:0] LANE_RIGHT  = 2'd2;

    localparam int Q_TL = 0;
    localparam int Q_TM = 1;
    localparam int Q_TR = 2;
    localparam int Q_ML = 3;
    localparam int Q_MM = 4;
    localparam int Q_MR = 5;
    localparam int Q_BL = 6;
    localparam int Q_BM = 7;
    localparam int Q_BR = 8;

    typedef struct packed {
        logic       lane_valid;
        logic [1:0] lane;
        logic       jump;
        logic       empty;
    } quad_decode_t;

endpackage

// File: rtl/vision_lane_controller_if.sv
// Frame bus between the quadrant detector (master) and the lane controller (slave).
interface vision_lane_controller_if;

    logic [8:0] quadrants_in;
    logic       quadrants_valid_in;
    logic [1:0] lane_out;
    logic       jump_out;
    logic       player_present_out;
    logic       update_out;
    logic [2:0] state_out;

    modport master (
        output quadrants_in,
        output quadrants_valid_in,
        input  lane_out,
        input  jump_out,
        input  player_present_out,
        input  update_out,
        input  state_out
    );

    modport slave (
        input  quadrants_in,
        input  quadrants_valid_in,
        output lane_out,
        output jump_out,
        output player_present_out,
        output update_out,
        output state_out
    );

endinterface

// File: rtl/vision_quadrant_decode.sv
// Combinational classification of one occupancy map into lane/jump/empty candidates.
module vision_quadrant_decode
    import vision_pkg::*;
(
    input  logic [8:0]   quadrants,
    output quad_decode_t decode
);

    logic [2:0] middle;
    assign middle = {quadrants[Q_MR], quadrants[Q_MM], quadrants[Q_ML]};

    always_comb begin
        // NOTE: every output is given a value before any branch, so no path leaves it unassigned and no latch is inferred.
        decode.lane_valid = 1'b1;
        decode.lane       = LANE_CENTRE;
        // A centre hit wins; a single side hit picks that side; both sides together is ambiguous.
        if (middle[1]) begin
            decode.lane = LANE_CENTRE;
        end else if (middle == 3'b001) begin
            decode.lane = LANE_LEFT;
        end else if (middle == 3'b100) begin
            decode.lane = LANE_RIGHT;
        end else begin
            decode.lane_valid = 1'b0;
        end
        decode.jump  = (|quadrants[Q_TR:Q_TL]) && !(|quadrants[Q_BR:Q_BL]);
        decode.empty = !(|quadrants);
    end

endmodule

// File: rtl/vision_lane_controller.sv
// Per-frame lane debounce and track/jump/cooldown FSM driven by quadrant maps.
// Optional frame watchdog (state LOST) is built when VISION_CTRL_WATCHDOG_EN is defined.
module vision_lane_controller
    import vision_pkg::*;
#(
    parameter int unsigned DEBOUNCE_FRAMES  = 3,
    parameter int unsigned ABSENT_FRAMES    = 8,
    parameter int unsigned JUMP_HOLD_FRAMES = 6,
    parameter int unsigned COOLDOWN_FRAMES  = 10,
    parameter int unsigned TIMEOUT_CYCLES   = 2000000
)
(
    input logic                      pixel_clock_in,
    input logic                      reset_n_in,
    vision_lane_controller_if.slave  bus
);

    if (DEBOUNCE_FRAMES < 1 || DEBOUNCE_FRAMES > 15 ||
        ABSENT_FRAMES < 1 || ABSENT_FRAMES > 255 ||
        JUMP_HOLD_FRAMES < 1 || JUMP_HOLD_FRAMES > 255 ||
        COOLDOWN_FRAMES > 255 || TIMEOUT_CYCLES < 1) begin : g_param_range
        $error("vision_lane_controller: parameter out of range");
    end

    localparam logic [3:0] DEBOUNCE_N = 4'(DEBOUNCE_FRAMES);
    localparam logic [7:0] ABSENT_N   = 8'(ABSENT_FRAMES);
    localparam logic [7:0] HOLD_N     = 8'(JUMP_HOLD_FRAMES);
    localparam logic [7:0] COOL_N     = 8'(COOLDOWN_FRAMES);

    ctrl_state_t  state_q, state_d;
    logic         valid_q;
    logic         update_q;
    logic [1:0]   lane_q, lane_d;
    logic [1:0]   last_q, last_d;
    logic         last_valid_q, last_valid_d;
    logic [3:0]   run_q, run_d;
    logic [7:0]   empty_q, empty_d;
    logic [7:0]   frame_q, frame_d;
    logic [7:0]   frame_inc;
    logic         frame_event;
    logic         absent;
    quad_decode_t dec;

    vision_quadrant_decode u_decode (
        .quadrants (bus.quadrants_in),
        .decode    (dec)
    );

    assign frame_event = bus.quadrants_valid_in && !valid_q;
    assign frame_inc   = frame_q + 8'd1;

`ifdef VISION_CTRL_WATCHDOG_EN
    localparam int unsigned     WD_W     = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT_CYCLES);

    logic [WD_W-1:0] wd_q, wd_d;

    // Saturates at the limit so LOST stays put until the next frame clears it.
    assign wd_d = frame_event ? '0 : ((wd_q == WD_LIMIT) ? wd_q : wd_q + WD_W'(1));

    always_ff @(posedge pixel_clock_in) begin
        if (!reset_n_in) wd_q <= '0;
        else             wd_q <= wd_d;
    end
`endif

    always_comb begin
        state_d      = state_q;
        lane_d       = lane_q;
        last_d       = last_q;
        last_valid_d = last_valid_q;
        run_d        = run_q;
        empty_d      = empty_q;
        frame_d      = frame_q;
        absent       = 1'b0;

        if (frame_event) begin
            if (dec.empty) empty_d = (empty_q == 8'hFF) ? empty_q : empty_q + 8'd1;
            else           empty_d = 8'd0;
            absent = (empty_d == ABSENT_N);

            if (state_q inside {ST_TRACK, ST_JUMP, ST_COOLDOWN}) begin
                if (!dec.lane_valid)                            run_d = 4'd0;
                else if (last_valid_q && (dec.lane == last_q))  run_d = (run_q == 4'hF) ? run_q : run_q + 4'd1;
                else                                            run_d = 4'd1;
                last_d       = dec.lane;
                last_valid_d = dec.lane_valid;
                if (dec.lane_valid && run_d >= DEBOUNCE_N) lane_d = dec.lane;
            end

            // Priority within one frame: absent, then hold/cooldown expiry, then jump entry.
            unique case (state_q)
                ST_IDLE: begin
                    if (!dec.empty) state_d = ST_TRACK;
                end
                ST_TRACK: begin
                    if (absent) begin
                        state_d = ST_IDLE;
                    end else if (dec.jump) begin
                        state_d = ST_JUMP;
                        frame_d = 8'd0;
                    end
                end
                ST_JUMP: begin
                    if (absent) begin
                        state_d = ST_IDLE;
                    end else if (frame_inc == HOLD_N) begin
                        state_d = ST_COOLDOWN;
                        frame_d = 8'd0;
                    end else begin
                        frame_d = frame_inc;
                    end
                end
                ST_COOLDOWN: begin
                    if (absent) begin
                        state_d = ST_IDLE;
                    end else if (frame_inc >= COOL_N) begin
                        state_d = ST_TRACK;
                        frame_d = 8'd0;
                    end else begin
                        frame_d = frame_inc;
                    end
                end
                ST_LOST: state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end

`ifdef VISION_CTRL_WATCHDOG_EN
        if (!frame_event && (wd_d == WD_LIMIT) && (state_q != ST_LOST)) begin
            state_d      = ST_LOST;
            last_d       = LANE_CENTRE;
            last_valid_d = 1'b0;
            run_d        = 4'd0;
            empty_d      = 8'd0;
            frame_d      = 8'd0;
        end
`endif
    end

    always_ff @(posedge pixel_clock_in) begin
        // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
        if (!reset_n_in) begin
            state_q      <= ST_IDLE;
            valid_q      <= 1'b0;
            update_q     <= 1'b0;
            lane_q       <= LANE_CENTRE;
            last_q       <= LANE_CENTRE;
            last_valid_q <= 1'b0;
            run_q        <= 4'd0;
            empty_q      <= 8'd0;
            frame_q      <= 8'd0;
        end else begin
            state_q      <= state_d;
            valid_q      <= bus.quadrants_valid_in;
            update_q     <= frame_event;
            lane_q       <= lane_d;
            last_q       <= last_d;
            last_valid_q <= last_valid_d;
            run_q        <= run_d;
            empty_q      <= empty_d;
            frame_q      <= frame_d;
        end
    end

    assign bus.lane_out           = lane_q;
    assign bus.jump_out           = (state_q == ST_JUMP);
    assign bus.player_present_out = state_q inside {ST_TRACK, ST_JUMP, ST_COOLDOWN};
    assign bus.update_out         = update_q;
    assign bus.state_out          = state_q;

endmodule

// File: tb/tb_vision_lane_controller.sv
// Directed scoreboard bench for vision_lane_controller; watchdog steps run when VISION_CTRL_WATCHDOG_EN is defined.
module tb_vision_lane_controller;

    typedef struct packed {
        logic [1:0] lane;
        logic       jump;
        logic       present;
        logic [2:0] state;
    } exp_t;

    logic pixel_clock_in = 1'b0;
    logic reset_n_in     = 1'b0;
    int   tests          = 0;
    int   fails          = 0;
    int   upd_cnt        = 0;
    int   base_cnt;
    exp_t sb[$];

    vision_lane_controller_if bus ();

    vision_lane_controller #(
        .DEBOUNCE_FRAMES  (3),
        .ABSENT_FRAMES    (8),
        .JUMP_HOLD_FRAMES (6),
        .COOLDOWN_FRAMES  (10),
        .TIMEOUT_CYCLES   (100)
    ) dut (
        .pixel_clock_in (pixel_clock_in),
        .reset_n_in     (reset_n_in),
        .bus            (bus)
    );

    always #5 pixel_clock_in = ~pixel_clock_in;

    task automatic check(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Scoreboard side: every update pulse consumes one expected frame result.
    always @(negedge pixel_clock_in) begin
        exp_t e;
        if (reset_n_in && bus.update_out) begin
            upd_cnt++;
            check("update_expected", int'(sb.size() != 0), 1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check($sformatf("upd%0d.lane", upd_cnt),    int'(bus.lane_out),           int'(e.lane));
                check($sformatf("upd%0d.jump", upd_cnt),    int'(bus.jump_out),           int'(e.jump));
                check($sformatf("upd%0d.present", upd_cnt), int'(bus.player_present_out), int'(e.present));
                check($sformatf("upd%0d.state", upd_cnt),   int'(bus.state_out),          int'(e.state));
            end
        end
    end

    task automatic send_frame(input logic [8:0] q, input int hold, input logic [1:0] lane,
                              input logic jump, input logic present, input logic [2:0] state);
        exp_t e;
        e = '{lane: lane, jump: jump, present: present, state: state};
        sb.push_back(e);
        @(negedge pixel_clock_in);
        bus.quadrants_in       = q;
        bus.quadrants_valid_in = 1'b1;
        repeat (hold) @(negedge pixel_clock_in);
        bus.quadrants_valid_in = 1'b0;
        @(posedge pixel_clock_in);
        for (int i = 0; i < 8 && sb.size() != 0; i++) @(posedge pixel_clock_in);
        check("scoreboard_drained", sb.size(), 0);
    endtask

    task automatic check_idle_reset(input string tag);
        check({tag, ".lane"},    int'(bus.lane_out),           1);
        check({tag, ".jump"},    int'(bus.jump_out),           0);
        check({tag, ".present"}, int'(bus.player_present_out), 0);
        check({tag, ".update"},  int'(bus.update_out),         0);
        check({tag, ".state"},   int'(bus.state_out),          0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "bench time limit expired");
    end

    initial begin
        bus.quadrants_in       = 9'h000;
        bus.quadrants_valid_in = 1'b0;
        reset_n_in             = 1'b0;
        repeat (3) @(posedge pixel_clock_in);
        @(negedge pixel_clock_in);
        reset_n_in = 1'b1;
        check_idle_reset("reset");

        // Centre-only map: first frame leaves IDLE, lane stays centre.
        for (int i = 0; i < 3; i++) send_frame(9'h010, 1, 2'd1, 1'b0, 1'b1, 3'd1);
        check("update_count_3", upd_cnt, 3);

        // Left for three frames: lane changes on the third.
        send_frame(9'h008, 1, 2'd1, 1'b0, 1'b1, 3'd1);
        send_frame(9'h008, 1, 2'd1, 1'b0, 1'b1, 3'd1);
        send_frame(9'h008, 1, 2'd0, 1'b0, 1'b1, 3'd1);

        // Two right frames interrupted by left: lane never goes right.
        send_frame(9'h020, 1, 2'd0, 1'b0, 1'b1, 3'd1);
        send_frame(9'h020, 1, 2'd0, 1'b0, 1'b1, 3'd1);
        send_frame(9'h008, 1, 2'd0, 1'b0, 1'b1, 3'd1);

        // Valid held for five cycles is a single frame.
        base_cnt = upd_cnt;
        send_frame(9'h008, 5, 2'd0, 1'b0, 1'b1, 3'd1);
        check("held_valid_one_update", upd_cnt - base_cnt, 1);

        // Jump entry, six frames high, lane debounce keeps running.
        send_frame(9'h012, 1, 2'd0, 1'b1, 1'b1, 3'd2);
        for (int e = 1; e <= 6; e++)
            send_frame(9'h012, 1, (e >= 2) ? 2'd1 : 2'd0, (e < 6), 1'b1, (e < 6) ? 3'd2 : 3'd3);

        // Cooldown ignores jump maps for ten frames, then re-arms.
        for (int c = 1; c <= 10; c++)
            send_frame(9'h012, 1, 2'd1, 1'b0, 1'b1, (c < 10) ? 3'd3 : 3'd1);
        send_frame(9'h012, 1, 2'd1, 1'b1, 1'b1, 3'd2);

        // Eight empty maps after jump entry: hold expires on the 6th, absent wins on the 8th.
        for (int e = 1; e <= 8; e++) begin
            if (e <= 5)      send_frame(9'h000, 1, 2'd1, 1'b1, 1'b1, 3'd2);
            else if (e <= 7) send_frame(9'h000, 1, 2'd1, 1'b0, 1'b1, 3'd3);
            else             send_frame(9'h000, 1, 2'd1, 1'b0, 1'b0, 3'd0);
        end

        // Reset in the middle of a jump returns straight to IDLE.
        send_frame(9'h010, 1, 2'd1, 1'b0, 1'b1, 3'd1);
        send_frame(9'h012, 1, 2'd1, 1'b1, 1'b1, 3'd2);
        @(negedge pixel_clock_in);
        reset_n_in = 1'b0;
        @(negedge pixel_clock_in);
        reset_n_in = 1'b1;
        check_idle_reset("reset_mid_jump");

`ifdef VISION_CTRL_WATCHDOG_EN
        send_frame(9'h010, 1, 2'd1, 1'b0, 1'b1, 3'd1);
        repeat (85) @(posedge pixel_clock_in);
        @(negedge pixel_clock_in);
        check("wd_before_timeout.state", int'(bus.state_out), 1);
        repeat (20) @(posedge pixel_clock_in);
        @(negedge pixel_clock_in);
        check("wd_lost.state",   int'(bus.state_out),          4);
        check("wd_lost.present", int'(bus.player_present_out), 0);
        check("wd_lost.jump",    int'(bus.jump_out),           0);
        check("wd_lost.lane",    int'(bus.lane_out),           1);
        send_frame(9'h010, 1, 2'd1, 1'b0, 1'b0, 3'd0);
`endif

        repeat (2) @(negedge pixel_clock_in);
        check("scoreboard_empty_at_end", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
